// File: rtl/pwm_bank_if.sv
// Host-side signal bundle for pwm_bank: timebase control, duty shadow writes
// and the registered PWM outputs.
interface pwm_bank_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 10
);
   localparam int unsigned ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                en;
   logic                mode;
   logic [WIDTH-1:0]    period;
   logic                wr_en;
   logic [ChW-1:0]      wr_ch;
   logic [WIDTH-1:0]    wr_duty;
   logic [CHANNELS-1:0] pwm_out;
   logic                cycle_start;

   modport master (
      output en, mode, period, wr_en, wr_ch, wr_duty,
      input  pwm_out, cycle_start
   );

   modport slave (
      input  en, mode, period, wr_en, wr_ch, wr_duty,
      output pwm_out, cycle_start
   );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM on a shared up / up-down timebase with shadowed duty,
// period and mode that only take effect at a cycle boundary.
module pwm_bank #(
   parameter int unsigned         CHANNELS = 4,
   parameter int unsigned         WIDTH    = 10,
   parameter logic [CHANNELS-1:0] INVERT   = '0
) (
   input logic        clk,
   input logic        rst,
   pwm_bank_if.slave  bus
);
   localparam int unsigned      ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   typedef enum logic {StUp, StDown} dir_e;

   dir_e                             dir_q, dir_d;
   logic [WIDTH-1:0]                 cnt_q, cnt_d;
   logic [WIDTH-1:0]                 per_act_q, per_eff;
   logic                             mode_act_q, mode_eff;
   logic [CHANNELS-1:0][WIDTH-1:0]   duty_sh_q, duty_sh_d;
   logic [CHANNELS-1:0][WIDTH-1:0]   duty_act_q, duty_eff;
   logic [CHANNELS-1:0]              pwm_q, pwm_d;
   logic                             cs_q, cs_d;
   logic                             boundary;

   assign boundary = bus.en && (cnt_q == '0) && (dir_q == StUp);

   // On the boundary clock the freshly loaded values already govern this clock.
   always_comb begin
      per_eff  = boundary ? bus.period : per_act_q;
      mode_eff = boundary ? bus.mode   : mode_act_q;
      duty_eff = boundary ? duty_sh_q  : duty_act_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q      <= StUp;
         cnt_q      <= '0;
         per_act_q  <= '0;
         mode_act_q <= 1'b0;
         duty_sh_q  <= '0;
         duty_act_q <= '0;
         pwm_q      <= INVERT;
         cs_q       <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         duty_sh_q <= duty_sh_d;
         pwm_q     <= pwm_d;
         cs_q      <= cs_d;
         if (boundary) begin
            per_act_q  <= bus.period;
            mode_act_q <= bus.mode;
            duty_act_q <= duty_sh_q;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!bus.en || (per_eff == '0)) begin
         cnt_d = '0;
         dir_d = StUp;
      end else if (!mode_eff) begin
         cnt_d = (cnt_q == per_eff) ? '0 : cnt_q + One;
         dir_d = StUp;
      end else if (dir_q == StUp) begin
         if (cnt_q == per_eff) begin
            cnt_d = per_eff - One;
            // per==1 turns straight back to zero, which is the next boundary.
            dir_d = (per_eff == One) ? StUp : StDown;
         end else begin
            cnt_d = cnt_q + One;
         end
      end else begin
         cnt_d = cnt_q - One;
         dir_d = (cnt_q == One) ? StUp : StDown;
      end
   end

   always_comb begin
      duty_sh_d = duty_sh_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.wr_en && (bus.wr_ch == ChW'(i))) duty_sh_d[i] = bus.wr_duty;
      end
   end

   always_comb begin
      pwm_d = INVERT;
      cs_d  = 1'b0;
      if (bus.en) begin
         cs_d = boundary;
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (cnt_q < duty_eff[i]) ^ INVERT[i];
         end
      end
   end

   assign bus.pwm_out     = pwm_q;
   assign bus.cycle_start = cs_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Randomized and directed bench for pwm_bank against a cycle-position model.
module tb_pwm_bank;
   localparam int unsigned   CHANNELS = 3;
   localparam int unsigned   WIDTH    = 10;
   localparam logic [2:0]    INV      = 3'b010;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pwm_bank_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

   pwm_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .INVERT(INV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: position within the cycle; counter value is derived in closed form.
   int         m_pos;
   int         m_per;
   bit         m_mode;
   int         m_act [CHANNELS];
   int         m_sh  [CHANNELS];
   logic [2:0] exp_out;
   logic       exp_cs;

   function automatic int cyc_len(int p, bit m);
      if (p == 0) return 1;
      return m ? 2 * p : p + 1;
   endfunction

   function automatic int cnt_at(int pos, int p, bit m);
      return (m && pos > p) ? 2 * p - pos : pos;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int c;
      if (rst) begin
         m_pos = 0; m_per = 0; m_mode = 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin m_act[i] = 0; m_sh[i] = 0; end
         exp_out = INV; exp_cs = 1'b0;
         return;
      end
      if (!bus.en) begin
         m_pos = 0; exp_out = INV; exp_cs = 1'b0;
      end else begin
         exp_cs = (m_pos == 0);
         if (exp_cs) begin
            m_per  = int'(bus.period);
            m_mode = bus.mode;
            for (int i = 0; i < CHANNELS; i++) m_act[i] = m_sh[i];
         end
         c = cnt_at(m_pos, m_per, m_mode);
         for (int i = 0; i < CHANNELS; i++) exp_out[i] = (c < m_act[i]) ^ INV[i];
         m_pos = (m_pos + 1) % cyc_len(m_per, m_mode);
      end
      if (bus.wr_en && int'(bus.wr_ch) < CHANNELS) m_sh[bus.wr_ch] = int'(bus.wr_duty);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("pwm_out", 32'(bus.pwm_out), 32'(exp_out));
      check_eq("cycle_start", 32'(bus.cycle_start), 32'(exp_cs));
      bus.wr_en = 1'b0;
   endtask

   task automatic write(input int ch, input int duty);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = 2'(ch);
      bus.wr_duty = 10'(duty);
      tick();
   endtask

   int highs, starts;

   initial begin
      rst = 1'b1;
      bus.en = 1'b0; bus.mode = 1'b0; bus.period = '0;
      bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_duty = '0;
      @(negedge clk);
      tick(); tick();
      check_eq("reset_out", 32'(bus.pwm_out), 32'(INV));
      check_eq("reset_cs", 32'(bus.cycle_start), 32'd0);
      rst = 1'b0;

      // Edge, period 9, duty 3.
      bus.period = 10'd9;
      write(0, 3);
      bus.en = 1'b1;
      tick();
      check_eq("first_start", 32'(bus.cycle_start), 32'd1);
      highs = int'(bus.pwm_out[0]); starts = 1;
      for (int k = 1; k < 30; k++) begin
         tick();
         highs += int'(bus.pwm_out[0]);
         starts += int'(bus.cycle_start);
      end
      check_eq("edge_highs", 32'(highs), 32'd9);
      check_eq("edge_starts", 32'(starts), 32'd3);

      // Duty 0 / 10 / 1023 extremes.
      write(0, 0); write(1, 10); write(2, 1023);
      for (int k = 0; k < 25; k++) tick();

      // Center, period 4, duty 2; restart from a clean boundary.
      write(0, 2);
      bus.en = 1'b0; tick();
      bus.mode = 1'b1; bus.period = 10'd4; bus.en = 1'b1;
      highs = 0; starts = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         highs += int'(bus.pwm_out[0]);
         starts += int'(bus.cycle_start);
      end
      check_eq("center_highs", 32'(highs), 32'd6);
      check_eq("center_starts", 32'(starts), 32'd2);

      // Shadow writes mid-cycle, then exactly on a boundary clock.
      write(0, 3); tick(); tick();
      write(0, 7);
      while (m_pos != 0) tick();
      write(0, 3);
      for (int k = 0; k < 20; k++) tick();

      // Disabled outputs, mid-cycle period change, out-of-range channel.
      bus.en = 1'b0; tick();
      check_eq("en0_out", 32'(bus.pwm_out), 32'(INV));
      write(3, 500);
      bus.en = 1'b1; bus.mode = 1'b0; tick(); tick();
      bus.period = 10'd2;
      for (int k = 0; k < 20; k++) tick();

      // Reset mid-cycle while counting down in center mode.
      bus.mode = 1'b1; bus.period = 10'd4;
      while (m_pos != 0) tick();
      for (int k = 0; k < 6; k++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check_eq("rst_out", 32'(bus.pwm_out), 32'(INV));
      check_eq("rst_cs", 32'(bus.cycle_start), 32'd0);
      for (int k = 0; k < 10; k++) tick();

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         rst = ($urandom_range(0, 299) == 0);
         bus.en = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 49) == 0) bus.mode = 1'($urandom);
         bus.period = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 12));
         bus.wr_en = ($urandom_range(0, 3) == 0);
         bus.wr_ch = 2'($urandom);
         bus.wr_duty = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 14));
         tick();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
